// File: rtl/shared_reg_arbiter_if.sv
// Bus between NREQ writers and the shared-register arbiter.
// Requesters drive req/lock/wdata. The arbiter returns grant, ack, register contents and owner.
interface shared_reg_arbiter_if #(
    parameter int unsigned N    = 64,
    parameter int unsigned NREQ = 4
);
    localparam int unsigned OW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*N-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [N-1:0]      q;
    logic [OW-1:0]     owner;
    logic              busy;

    modport master (output req, lock, wdata, input gnt, ack, q, owner, busy);
    modport slave  (input req, lock, wdata, output gnt, ack, q, owner, busy);
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer that owns a shared N-bit register.
// Lock lets one owner make a bounded run of consecutive writes.
module shared_reg_arbiter #(
    parameter int unsigned N        = 64,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    shared_reg_arbiter_if.slave bus
);
    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t          r_state, w_state_nxt;
    logic [OW-1:0]   r_owner, w_owner_nxt;
    logic [OW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [HW-1:0]   r_hold_cnt, w_hold_cnt_nxt;
    logic [N-1:0]    r_q, w_q_nxt;
    logic [NREQ-1:0] r_ack, w_ack_nxt;
    logic [NREQ-1:0] w_gnt;
    logic [OW-1:0]   w_ptr_rel;
    logic            w_own_req;
    logic            w_keep;

    function automatic logic [OW-1:0] f_pick(input logic [NREQ-1:0] req,
                                             input logic [OW-1:0]   ptr);
        logic [OW-1:0] win;
        logic          found;
        int unsigned   idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
        return win;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_q        <= '0;
            r_ack      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_q        <= w_q_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    assign w_ptr_rel = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_own_req = bus.req[r_owner];
    assign w_keep    = w_own_req && bus.lock[r_owner] && (r_hold_cnt < HW'(MAX_HOLD - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_q_nxt        = r_q;
        w_ack_nxt      = '0;
        w_gnt          = '0;
        unique case (r_state)
            S_IDLE: begin
                if (|bus.req) begin
                    w_state_nxt    = S_OWN;
                    w_owner_nxt    = f_pick(bus.req, r_rr_ptr);
                    w_hold_cnt_nxt = '0;
                end
            end
            S_OWN: begin
                w_gnt[r_owner] = 1'b1;
                if (w_own_req) begin
                    w_q_nxt            = bus.wdata[32'(r_owner)*N +: N];
                    w_ack_nxt[r_owner] = 1'b1;
                end
                if (w_keep) begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end else begin
                    // Re-arbitrate against the advanced pointer in the same edge, so there is no idle bubble.
                    w_rr_ptr_nxt   = w_ptr_rel;
                    w_hold_cnt_nxt = '0;
                    if (|bus.req) begin
                        w_owner_nxt = f_pick(bus.req, w_ptr_rel);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.gnt   = w_gnt;
    assign bus.ack   = r_ack;
    assign bus.q     = r_q;
    assign bus.owner = r_owner;
    assign bus.busy  = (r_state == S_OWN);
endmodule
